// File: rtl/hafsa_sopc_dct_pkg.sv
// Shared definitions for the DCT trace packer: atom/buffer geometry,
// trace atom encodings and the end-of-test FSM state type.
package hafsa_sopc_dct_pkg;

    localparam int ATOM_W = 2;
    localparam int BUF_W  = 30;
    localparam int SLOTS  = BUF_W / ATOM_W;
    localparam int CNT_W  = 4;

    // Trace atom encodings as produced by the CPU trace source
    typedef enum logic [ATOM_W-1:0] {
        ATOM_NONE      = 2'b00,
        ATOM_NOT_TAKEN = 2'b01,
        ATOM_TAKEN     = 2'b10,
        ATOM_EXCEPTION = 2'b11
    } atom_e;

    // End-of-test sequencing
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENDED = 2'd2
    } state_e;

endpackage

// File: rtl/hafsa_sopc_dct_frame_reg.sv
// Single-entry valid/ready output register holding one packed trace frame.
// Contents stay stable while valid is high and the consumer is not ready.
module hafsa_sopc_dct_frame_reg #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  count
);

    // Capture a new frame on load; otherwise retire the held frame on acceptance
    always_ff @(posedge clk) begin
        // NOTE: the payload is reset too, not only valid, so the port reads all zeros after reset.
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            count <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            count <= load_count;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hafsa_sopc_cpu_dct_packer.sv
// Packs 2-bit CPU trace atoms into 30-bit frames (15 atoms per frame), hands
// full or flushed frames to the trace store over valid/ready, and drains the
// partial frame at end of test.
// Optional feature: define HAFSA_SOPC_DCT_DROP_CNT_EN to add a saturating
// 16-bit drop_count output counting discarded atoms.
module hafsa_sopc_cpu_dct_packer
    import hafsa_sopc_dct_pkg::*;
#(
    parameter int ATOM_W = hafsa_sopc_dct_pkg::ATOM_W,
    parameter int BUF_W  = hafsa_sopc_dct_pkg::BUF_W,
    parameter int CNT_W  = hafsa_sopc_dct_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom_code,
    input  logic              flush,
    input  logic              end_test_req,
    output logic              frame_valid,
    output logic [BUF_W-1:0]  frame_data,
    output logic [CNT_W-1:0]  frame_count,
    input  logic              frame_ready,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              overflow,
`ifdef HAFSA_SOPC_DCT_DROP_CNT_EN
    output logic [15:0]       drop_count,
`endif
    output logic              test_ending,
    output logic              test_has_ended
);

    localparam int              NUM_SLOTS = BUF_W / ATOM_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

    state_e           state;
    logic [BUF_W-1:0] buf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             flush_pend;
    logic             overflow_q;

    logic run;
    logic full;
    logic flush_req;
    logic do_xfer;
    logic take;
    logic drop;

    // Transfer, accept and drop decisions for the current cycle
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        run       = 1'b0;
        full      = 1'b0;
        flush_req = 1'b0;
        do_xfer   = 1'b0;
        take      = 1'b0;
        drop      = 1'b0;

        run       = (state == ST_RUN);
        full      = (cnt_q == FULL_CNT);
        flush_req = flush_pend || (state == ST_DRAIN);
        // Never move an empty buffer; only move when the frame register is free or emptying.
        do_xfer   = (full || flush_req) && (cnt_q != '0) && (!frame_valid || frame_ready);
        // A transfer frees slot 0 in the same cycle, so a full buffer can still take an atom.
        take      = run && atom_valid && (do_xfer || !full);
        drop      = run && atom_valid && full && !do_xfer;
    end

    // Packing buffer and atom count
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (reset) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else if (do_xfer) begin
            if (take) begin
                buf_q <= BUF_W'(atom_code);
                cnt_q <= CNT_W'(1);
            end else begin
                buf_q <= '0;
                cnt_q <= '0;
            end
        end else if (take) begin
            buf_q[ATOM_W*cnt_q +: ATOM_W] <= atom_code;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Pending flush: set by a RUN-state flush, cleared by a transfer or an empty buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_pend <= 1'b0;
        end else if (run && flush) begin
            flush_pend <= 1'b1;
        end else if (do_xfer || (cnt_q == '0)) begin
            flush_pend <= 1'b0;
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef HAFSA_SOPC_DCT_DROP_CNT_EN
    // Saturating count of dropped atoms
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

    // End-of-test FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_RUN;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (end_test_req) begin
                        state       <= ST_DRAIN;
                        test_ending <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if ((cnt_q == '0) && !frame_valid) begin
                        state          <= ST_ENDED;
                        test_ending    <= 1'b0;
                        test_has_ended <= 1'b1;
                    end
                end
                ST_ENDED: begin
                    state <= ST_ENDED;
                end
                default: begin
                    state          <= ST_RUN;
                    test_ending    <= 1'b0;
                    test_has_ended <= 1'b0;
                end
            endcase
        end
    end

    hafsa_sopc_dct_frame_reg #(
        .DATA_W (BUF_W),
        .CNT_W  (CNT_W)
    ) u_frame_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (do_xfer),
        .load_data  (buf_q),
        .load_count (cnt_q),
        .ready      (frame_ready),
        .valid      (frame_valid),
        .data       (frame_data),
        .count      (frame_count)
    );

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_hafsa_sopc_cpu_dct_packer.sv
// Scoreboard bench for hafsa_sopc_cpu_dct_packer: directed stimulus pushes
// hand-computed frames into a queue; a negedge monitor pops and compares on
// every accepted frame. Define HAFSA_SOPC_DCT_DROP_CNT_EN to cover drop_count.
module tb_hafsa_sopc_cpu_dct_packer;

    typedef struct packed {
        logic [29:0] data;
        logic [3:0]  count;
    } frame_t;

    logic        clk;
    logic        reset;
    logic        atom_valid;
    logic [1:0]  atom_code;
    logic        flush;
    logic        end_test_req;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic        frame_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic        test_ending;
    logic        test_has_ended;
`ifdef HAFSA_SOPC_DCT_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int     tests_run = 0;
    int     tests_failed = 0;
    frame_t exp_q[$];

    hafsa_sopc_cpu_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom_code      (atom_code),
        .flush          (flush),
        .end_test_req   (end_test_req),
        .frame_valid    (frame_valid),
        .frame_data     (frame_data),
        .frame_count    (frame_count),
        .frame_ready    (frame_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow),
`ifdef HAFSA_SOPC_DCT_DROP_CNT_EN
        .drop_count     (drop_count),
`endif
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_atom(input logic [1:0] code);
        atom_valid = 1'b1;
        atom_code  = code;
        tick(1);
        atom_valid = 1'b0;
        atom_code  = 2'b00;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic expect_frame(input logic [29:0] d, input logic [3:0] c);
        frame_t f;
        f.data  = d;
        f.count = c;
        exp_q.push_back(f);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_frame_valid"},    32'(frame_valid),    32'd0);
        check({tag, "_frame_data"},     32'(frame_data),     32'd0);
        check({tag, "_frame_count"},    32'(frame_count),    32'd0);
        check({tag, "_dct_buffer"},     32'(dct_buffer),     32'd0);
        check({tag, "_dct_count"},      32'(dct_count),      32'd0);
        check({tag, "_overflow"},       32'(overflow),       32'd0);
        check({tag, "_test_ending"},    32'(test_ending),    32'd0);
        check({tag, "_test_has_ended"}, 32'(test_has_ended), 32'd0);
`ifdef HAFSA_SOPC_DCT_DROP_CNT_EN
        check({tag, "_drop_count"},     32'(drop_count),     32'd0);
`endif
    endtask

    // Monitor: every accepted frame must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'(frame_data), 32'hFFFF_FFFF);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                check("frame_data",  32'(frame_data),  32'(e.data));
                check("frame_count", 32'(frame_count), 32'(e.count));
            end
        end
    end

    initial begin
        reset        = 1'b1;
        atom_valid   = 1'b0;
        atom_code    = 2'b00;
        flush        = 1'b0;
        end_test_req = 1'b0;
        frame_ready  = 1'b1;
        tick(2);
        check_all_zero("reset");
        reset = 1'b0;
        tick(1);

        // 1: fifteen taken atoms -> one full frame, one cycle after the 15th capture
        expect_frame(30'h2AAA_AAAA, 4'd15);
        for (int i = 0; i < 15; i++) send_atom(2'b10);
        check("t1_count_full",  32'(dct_count),   32'd15);
        check("t1_not_yet",     32'(frame_valid), 32'd0);
        tick(1);
        check("t1_valid",       32'(frame_valid), 32'd1);
        check("t1_count_clear", 32'(dct_count),   32'd0);
        check("t1_buf_clear",   32'(dct_buffer),  32'd0);
        tick(1);
        check("t1_valid_drop",  32'(frame_valid), 32'd0);

        // 2: partial frame via flush, then a flush of an empty buffer
        expect_frame(30'h0000_0039, 4'd3);
        send_atom(2'b01);
        send_atom(2'b10);
        send_atom(2'b11);
        check("t2_buf",   32'(dct_buffer), 32'h39);
        check("t2_count", 32'(dct_count),  32'd3);
        pulse_flush();
        tick(3);
        check("t2_count_clear", 32'(dct_count), 32'd0);
        pulse_flush();
        tick(3);
        check("t2_no_empty_frame", 32'(frame_valid), 32'd0);

        // 3: consumer stalled, 31 atoms -> held frame, full buffer, one drop
        frame_ready = 1'b0;
        expect_frame(30'h1555_5555, 4'd15);
        expect_frame(30'h3FFF_FFFF, 4'd15);
        for (int i = 0; i < 15; i++) send_atom(2'b01);
        for (int i = 0; i < 16; i++) send_atom(2'b11);
        check("t3_overflow",   32'(overflow),    32'd1);
        check("t3_held_valid", 32'(frame_valid), 32'd1);
        check("t3_held_data",  32'(frame_data),  32'h1555_5555);
        check("t3_full_count", 32'(dct_count),   32'd15);
        check("t3_full_buf",   32'(dct_buffer),  32'h3FFF_FFFF);
`ifdef HAFSA_SOPC_DCT_DROP_CNT_EN
        check("t3_drop_count", 32'(drop_count),  32'd1);
`endif
        tick(3);
        check("t3_stable_data",  32'(frame_data),  32'h1555_5555);
        check("t3_stable_count", 32'(frame_count), 32'd15);
        frame_ready = 1'b1;
        tick(3);
        check("t3_drained", 32'(dct_count), 32'd0);
        check("t3_sticky",  32'(overflow),  32'd1);

        // 4: atom arriving during the transfer of a full buffer lands in slot 0
        expect_frame(30'h2AAA_AAAA, 4'd15);
        for (int i = 0; i < 15; i++) send_atom(2'b10);
        send_atom(2'b11);
        check("t4_count", 32'(dct_count),  32'd1);
        check("t4_buf",   32'(dct_buffer), 32'h3);
        expect_frame(30'h0000_0003, 4'd1);
        pulse_flush();
        tick(3);

        // 5: end-of-test drain of a 5-atom partial frame
        frame_ready = 1'b0;
        expect_frame(30'h0000_03A5, 4'd5);
        send_atom(2'b01);
        send_atom(2'b01);
        send_atom(2'b10);
        send_atom(2'b10);
        send_atom(2'b11);
        end_test_req = 1'b1;
        tick(1);
        end_test_req = 1'b0;
        check("t5_ending",       32'(test_ending),    32'd1);
        tick(1);
        check("t5_drain_valid",  32'(frame_valid),    32'd1);
        check("t5_drain_data",   32'(frame_data),     32'h3A5);
        check("t5_drain_count",  32'(frame_count),    32'd5);
        tick(2);
        check("t5_not_ended",    32'(test_has_ended), 32'd0);
        frame_ready = 1'b1;
        tick(2);
        check("t5_ended",        32'(test_has_ended), 32'd1);
        check("t5_ending_low",   32'(test_ending),    32'd0);
        send_atom(2'b10);
        send_atom(2'b11);
        pulse_flush();
        end_test_req = 1'b1;
        tick(2);
        end_test_req = 1'b0;
        check("t5_atoms_ignored", 32'(dct_count),      32'd0);
        check("t5_still_ended",   32'(test_has_ended), 32'd1);
        check("t5_no_frame",      32'(frame_valid),    32'd0);

        // 6: reset mid-frame with a held frame and 7 buffered atoms
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_all_zero("t6_pre");
        frame_ready = 1'b0;
        for (int i = 0; i < 22; i++) send_atom(2'b10);
        check("t6_mid_count", 32'(dct_count),   32'd7);
        check("t6_mid_valid", 32'(frame_valid), 32'd1);
        reset = 1'b1;
        tick(1);
        check_all_zero("t6_post");
        reset = 1'b0;
        frame_ready = 1'b1;
        tick(3);
        check("t6_no_stale_frame", 32'(frame_valid), 32'd0);
        expect_frame(30'h0000_0002, 4'd1);
        send_atom(2'b10);
        pulse_flush();
        tick(3);
        check("t6_run_after_reset", 32'(test_ending), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
